// File: rtl/count_snapshot_if.sv
// count_snapshot_if
// Snapshot delivery bus between count_snapshot (master) and its consumer
// (slave). Carries a valid/ready handshake plus the settled count, the
// modular delta since the previous accepted snapshot, the wrap flag and the
// forced-capture error flag.
//
// Signals:
//   snap_valid  master->slave  snapshot fields are valid
//   snap_ready  slave->master  consumer accepts the snapshot
//   snap_value  master->slave  settled counter value
//   snap_delta  master->slave  snap_value minus previous accepted value
//   snap_wrap   master->slave  counter wrapped since previous accepted value
//   snap_err    master->slave  capture was forced without agreement
interface count_snapshot_if #(
    parameter int WIDTH = 32
);
    logic             snap_valid;
    logic             snap_ready;
    logic [WIDTH-1:0] snap_value;
    logic [WIDTH-1:0] snap_delta;
    logic             snap_wrap;
    logic             snap_err;

    modport master (
        output snap_valid,
        output snap_value,
        output snap_delta,
        output snap_wrap,
        output snap_err,
        input  snap_ready
    );

    modport slave (
        input  snap_valid,
        input  snap_value,
        input  snap_delta,
        input  snap_wrap,
        input  snap_err,
        output snap_ready
    );
endinterface

// File: rtl/count_snapshot.sv
// count_snapshot
// Samples the asynchronously settling q bus of a ripple counter. A free
// running three-stage chain brings the bus into the clock domain; on a
// capture request the block waits until two consecutive synchronised samples
// agree (or forces a flagged capture after MAX_TRIES attempts), then presents
// the value, the modular delta from the last accepted snapshot and a wrap
// flag on a valid/ready bus.
//
// Parameters:
//   WIDTH      counter width, must match the ripple counter
//   MAX_TRIES  settle attempts before a forced capture (2..255)
//
// Ports:
//   clock    sampling clock, rising edge
//   reset    asynchronous active-low reset
//   cnt_in   raw ripple counter bus, asynchronous to clock
//   cap_req  capture request, honoured in IDLE and on a HOLD handshake
//   busy     high while settling or holding a snapshot
//   snap     snapshot delivery bus (master side)
module count_snapshot #(
    parameter int WIDTH     = 32,
    parameter int MAX_TRIES = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             cap_req,
    output logic             busy,
    count_snapshot_if.master snap
);

    localparam int TRIES_W = $clog2(MAX_TRIES) + 1;
    localparam logic [TRIES_W-1:0] TRIES_LAST = TRIES_W'(MAX_TRIES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state_q,      state_d;
    logic [WIDTH-1:0]   r1_q,         r1_d;
    logic [WIDTH-1:0]   r2_q,         r2_d;
    logic [WIDTH-1:0]   r3_q,         r3_d;
    logic [TRIES_W-1:0] tries_q,      tries_d;
    logic [WIDTH-1:0]   last_value_q, last_value_d;
    logic [WIDTH-1:0]   snap_value_q, snap_value_d;
    logic [WIDTH-1:0]   snap_delta_q, snap_delta_d;
    logic               snap_wrap_q,  snap_wrap_d;
    logic               snap_err_q,   snap_err_d;
    logic               snap_valid_q, snap_valid_d;
    logic               busy_q,       busy_d;
    logic               stable;

    // Next-state logic. The sync chain shifts every cycle regardless of the
    // FSM so the stability test always looks at fresh samples. busy and
    // snap_valid are decoded from the next state and registered, keeping
    // every output a plain flop.
    always_comb begin
        r1_d         = cnt_in;
        r2_d         = r1_q;
        r3_d         = r2_q;
        state_d      = state_q;
        tries_d      = tries_q;
        last_value_d = last_value_q;
        snap_value_d = snap_value_q;
        snap_delta_d = snap_delta_q;
        snap_wrap_d  = snap_wrap_q;
        snap_err_d   = snap_err_q;

        stable = (r2_q == r3_q);

        case (state_q)
            IDLE: begin
                if (cap_req) begin
                    state_d = SETTLE;
                    tries_d = '0;
                end
            end
            SETTLE: begin
                // A forced capture still takes r2 so the consumer gets the
                // freshest sample, with snap_err marking it as unreliable.
                if (stable || (tries_q == TRIES_LAST)) begin
                    snap_value_d = r2_q;
                    snap_delta_d = r2_q - last_value_q;
                    snap_wrap_d  = (r2_q < last_value_q);
                    snap_err_d   = !stable;
                    state_d      = HOLD;
                end else begin
                    tries_d = tries_q + TRIES_W'(1);
                end
            end
            HOLD: begin
                // Requests without a handshake are dropped, not queued.
                if (snap.snap_ready) begin
                    last_value_d = snap_value_q;
                    if (cap_req) begin
                        state_d = SETTLE;
                        tries_d = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d       = (state_d != IDLE);
        snap_valid_d = (state_d == HOLD);
    end

    // State registers; reset discards any snapshot in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            r1_q         <= '0;
            r2_q         <= '0;
            r3_q         <= '0;
            tries_q      <= '0;
            last_value_q <= '0;
            snap_value_q <= '0;
            snap_delta_q <= '0;
            snap_wrap_q  <= 1'b0;
            snap_err_q   <= 1'b0;
            snap_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            r1_q         <= r1_d;
            r2_q         <= r2_d;
            r3_q         <= r3_d;
            tries_q      <= tries_d;
            last_value_q <= last_value_d;
            snap_value_q <= snap_value_d;
            snap_delta_q <= snap_delta_d;
            snap_wrap_q  <= snap_wrap_d;
            snap_err_q   <= snap_err_d;
            snap_valid_q <= snap_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign busy            = busy_q;
    assign snap.snap_valid = snap_valid_q;
    assign snap.snap_value = snap_value_q;
    assign snap.snap_delta = snap_delta_q;
    assign snap.snap_wrap  = snap_wrap_q;
    assign snap.snap_err   = snap_err_q;

endmodule

// File: tb/tb_count_snapshot.sv
// tb_count_snapshot
// Self-checking bench for count_snapshot. Expected snapshots are pushed to a
// scoreboard queue when a capture is requested and popped when the DUT
// presents snap_valid. The bench tracks the last accepted value itself to
// derive expected delta and wrap.
module tb_count_snapshot;

    typedef struct {
        logic [31:0] value;
        logic [31:0] delta;
        logic        wrap;
        logic        err;
    } snap_t;

    logic        clock;
    logic        reset;
    logic [31:0] cnt_in;
    logic        cap_req;
    logic        busy;

    int          checkCount;
    int          errorCount;
    logic [31:0] benchLast;
    snap_t       heldExp;
    snap_t       sb[$];

    count_snapshot_if #(.WIDTH(32)) snapBus();

    count_snapshot #(
        .WIDTH     (32),
        .MAX_TRIES (8)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .cnt_in  (cnt_in),
        .cap_req (cap_req),
        .busy    (busy),
        .snap    (snapBus.master)
    );

    // Free-running 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case anything stalls far beyond the expected run length.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Advance to just after the next rising edge, away from the sampling point.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Record the snapshot the DUT should produce for a captured value.
    task automatic pushExpected(input logic [31:0] v, input logic err);
        snap_t e;
        e.value = v;
        e.delta = v - benchLast;
        e.wrap  = (v < benchLast);
        e.err   = err;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare it with the presented snapshot.
    task automatic compareSnapshot(input string tag);
        if (sb.size() == 0) begin
            checkOutput({tag, "_sb_empty"}, 32'(1), 32'(0));
        end else begin
            heldExp = sb.pop_front();
            checkOutput({tag, "_valid"}, 32'(snapBus.snap_valid), 32'(1));
            checkOutput({tag, "_value"}, snapBus.snap_value, heldExp.value);
            checkOutput({tag, "_delta"}, snapBus.snap_delta, heldExp.delta);
            checkOutput({tag, "_wrap"},  32'(snapBus.snap_wrap), 32'(heldExp.wrap));
            checkOutput({tag, "_err"},   32'(snapBus.snap_err),  32'(heldExp.err));
        end
    endtask

    // Check that every output sits at its reset value.
    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"},  32'(busy), 32'(0));
        checkOutput({tag, "_valid"}, 32'(snapBus.snap_valid), 32'(0));
        checkOutput({tag, "_value"}, snapBus.snap_value, 32'(0));
        checkOutput({tag, "_delta"}, snapBus.snap_delta, 32'(0));
        checkOutput({tag, "_wrap"},  32'(snapBus.snap_wrap), 32'(0));
        checkOutput({tag, "_err"},   32'(snapBus.snap_err),  32'(0));
    endtask

    // Hold a stable value on the bus, request a capture and verify the
    // best-case two-edge latency and the delivered snapshot.
    task automatic applyStimulus(input string tag, input logic [31:0] v);
        cnt_in = v;
        repeat (3) tick();
        pushExpected(v, 1'b0);
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        checkOutput({tag, "_busy_n"},  32'(busy), 32'(1));
        checkOutput({tag, "_valid_n"}, 32'(snapBus.snap_valid), 32'(0));
        tick();
        compareSnapshot(tag);
    endtask

    // Complete the handshake and confirm snap_valid drops afterwards.
    task automatic acceptSnapshot(input string tag);
        snapBus.snap_ready = 1'b1;
        tick();
        snapBus.snap_ready = 1'b0;
        benchLast = heldExp.value;
        checkOutput({tag, "_valid_low"}, 32'(snapBus.snap_valid), 32'(0));
        checkOutput({tag, "_busy_low"},  32'(busy), 32'(0));
    endtask

    // Main test sequence.
    initial begin
        int firstValid;
        checkCount = 0;
        errorCount = 0;
        benchLast  = '0;
        reset      = 1'b1;
        cnt_in     = 32'hDEAD_BEEF;
        cap_req    = 1'b1;
        snapBus.snap_ready = 1'b1;

        // Reset with arbitrary inputs applied.
        #3 reset = 1'b0;
        #2 checkAllZero("reset");
        tick();
        tick();
        checkAllZero("reset_held");
        cap_req = 1'b0;
        snapBus.snap_ready = 1'b0;
        cnt_in = 32'h1234_5678;
        reset  = 1'b1;
        repeat (4) tick();
        checkOutput("idle_busy",  32'(busy), 32'(0));
        checkOutput("idle_valid", 32'(snapBus.snap_valid), 32'(0));

        // Basic capture, then a wrapping capture.
        applyStimulus("basic", 32'h0000_00FF);
        acceptSnapshot("basic");
        applyStimulus("wrap", 32'h0000_0010);
        acceptSnapshot("wrap");

        // Bus toggling every cycle never agrees: forced capture after
        // MAX_TRIES edges. Request at loop edge 4, forced capture at edge 12
        // takes the value sampled at edge 10.
        firstValid = -1;
        for (int t = 0; t <= 16; t++) begin
            cnt_in  = (t % 2 == 1) ? 32'h0000_0000 : 32'hFFFF_FFFF;
            cap_req = (t == 4);
            if (t == 4) pushExpected(32'hFFFF_FFFF, 1'b1);
            tick();
            if (firstValid < 0 && snapBus.snap_valid) firstValid = t;
        end
        cap_req = 1'b0;
        checkOutput("unstable_latency", 32'(firstValid), 32'(12));
        compareSnapshot("unstable");
        acceptSnapshot("unstable");

        // Backpressure: outputs hold while the bus changes and requests
        // arrive, then a handshake with cap_req starts a back-to-back capture.
        applyStimulus("bp_first", 32'h0000_1000);
        for (int i = 0; i < 10; i++) begin
            cnt_in  = (i < 7) ? $urandom : 32'h0000_2000;
            cap_req = (i % 2 == 0);
            tick();
            checkOutput("bp_hold_valid", 32'(snapBus.snap_valid), 32'(1));
            checkOutput("bp_hold_value", snapBus.snap_value, heldExp.value);
            checkOutput("bp_hold_delta", snapBus.snap_delta, heldExp.delta);
            checkOutput("bp_hold_wrap",  32'(snapBus.snap_wrap), 32'(heldExp.wrap));
            checkOutput("bp_hold_err",   32'(snapBus.snap_err),  32'(heldExp.err));
        end
        snapBus.snap_ready = 1'b1;
        cap_req = 1'b1;
        benchLast = heldExp.value;
        pushExpected(32'h0000_2000, 1'b0);
        tick();
        snapBus.snap_ready = 1'b0;
        cap_req = 1'b0;
        checkOutput("b2b_gap_valid", 32'(snapBus.snap_valid), 32'(0));
        checkOutput("b2b_gap_busy",  32'(busy), 32'(1));
        tick();
        compareSnapshot("b2b");
        acceptSnapshot("b2b");

        // Reset while settling: everything clears immediately.
        cnt_in = 32'h0000_0055;
        repeat (3) tick();
        cap_req = 1'b1;
        tick();
        cap_req = 1'b0;
        checkOutput("settle_busy", 32'(busy), 32'(1));
        #1 reset = 1'b0;
        #1 checkAllZero("rst_settle");
        tick();
        reset = 1'b1;
        benchLast = '0;
        repeat (3) tick();
        checkOutput("rst_settle_no_valid", 32'(snapBus.snap_valid), 32'(0));

        // Reset while holding a snapshot: discarded with no handshake.
        applyStimulus("pre_hold_rst", 32'h0000_0066);
        #1 reset = 1'b0;
        #1 checkAllZero("rst_hold");
        tick();
        reset = 1'b1;
        benchLast = '0;
        repeat (3) tick();
        checkOutput("rst_hold_no_valid", 32'(snapBus.snap_valid), 32'(0));

        // last_value must have been cleared: delta equals the new value.
        applyStimulus("after_rst", 32'h0000_0020);
        acceptSnapshot("after_rst");

        checkOutput("sb_drained", 32'(sb.size()), 32'(0));
        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
